// File: rtl/wave_player.sv
// WAV ROM player: parses a RIFF/WAVE header, then streams PCM frames at the file's sample rate.
// States IDLE/HDR/FETCH/WAIT/DONE/ERR; define WAVE_PLAYER_HDR_CHECK_EN to enforce the RIFF/WAVE magic.
module wave_player #(
    parameter int unsigned SYSCLOCK = 40000000,
    parameter int          ADDR_W   = 28
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_START,
    input  logic [ADDR_W-1:0] I_BASE_ADDR,
    input  logic              I_LOOP,
    input  logic              I_PAUSE,
    output logic [ADDR_W-1:0] O_ADDR,
    output logic              O_READ,
    input  logic [7:0]        I_DATA,
    input  logic              I_READY,
    output logic [15:0]       O_PCM_L,
    output logic [15:0]       O_PCM_R,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic              O_ERR,
    output logic              O_UNDERRUN
);
    localparam int AW1 = ADDR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_WAIT, S_DONE, S_ERR} state_t;

    state_t            state;
    logic              pending;
    logic              underrun;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] data_start;
    logic [ADDR_W-1:0] end_addr;
    logic [5:0]        hdr_idx;
    logic [15:0]       num_ch;
    logic [15:0]       bps;
    logic [31:0]       hdr_rate;
    logic [23:0]       size_lo;
    logic [31:0]       rate;
    logic [31:0]       acc;
    logic              stereo;
    logic              wide;
    logic [2:0]        frame_bytes;
    logic [2:0]        frame_idx;
    logic [31:0]       staging;
    logic [32:0]       acc_sum;
    logic              running;
    logic              tick;
    logic              got_byte;
    logic              at_end;
    logic              hdr_bad;
    logic              magic_bad;
    logic [15:0]       next_l;
    logic [15:0]       next_r;

    assign running  = (state == S_HDR) || (state == S_FETCH) || (state == S_WAIT);
    assign acc_sum  = {1'b0, acc} + {1'b0, rate};
    assign tick     = running && (acc_sum >= 33'(SYSCLOCK));
    assign got_byte = pending && I_READY;
    // A frame that would run past end_addr is treated as end of data, dropping any partial tail.
    assign at_end   = ({1'b0, addr} + AW1'(frame_bytes)) > {1'b0, end_addr};
    assign hdr_bad  = !((num_ch == 16'd1) || (num_ch == 16'd2)) || !((bps == 16'd8) || (bps == 16'd16));

    assign O_BUSY     = running;
    assign O_DONE     = (state == S_DONE);
    assign O_ERR      = (state == S_ERR);
    assign O_UNDERRUN = underrun;

`ifdef WAVE_PLAYER_HDR_CHECK_EN
    always_comb begin
        magic_bad = 1'b0;
        case (hdr_idx)
            6'd0:    magic_bad = (I_DATA != 8'h52);
            6'd1:    magic_bad = (I_DATA != 8'h49);
            6'd2:    magic_bad = (I_DATA != 8'h46);
            6'd3:    magic_bad = (I_DATA != 8'h46);
            6'd8:    magic_bad = (I_DATA != 8'h57);
            6'd9:    magic_bad = (I_DATA != 8'h41);
            6'd10:   magic_bad = (I_DATA != 8'h56);
            6'd11:   magic_bad = (I_DATA != 8'h45);
            default: magic_bad = 1'b0;
        endcase
    end
`else
    assign magic_bad = 1'b0;
`endif

    always_comb begin
        next_l = staging[15:0];
        next_r = staging[15:0];
        case ({stereo, wide})
            2'b00: begin
                next_l = {staging[7:0] ^ 8'h80, 8'h00};
                next_r = {staging[7:0] ^ 8'h80, 8'h00};
            end
            2'b10: begin
                next_l = {staging[7:0] ^ 8'h80, 8'h00};
                next_r = {staging[15:8] ^ 8'h80, 8'h00};
            end
            2'b11:   next_r = staging[31:16];
            default: next_r = staging[15:0];
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state       <= S_IDLE;
            O_READ      <= 1'b0;
            O_ADDR      <= '0;
            O_PCM_L     <= '0;
            O_PCM_R     <= '0;
            pending     <= 1'b0;
            underrun    <= 1'b0;
            addr        <= '0;
            data_start  <= '0;
            end_addr    <= '0;
            hdr_idx     <= '0;
            num_ch      <= '0;
            bps         <= '0;
            hdr_rate    <= '0;
            size_lo     <= '0;
            rate        <= '0;
            acc         <= '0;
            stereo      <= 1'b0;
            wide        <= 1'b0;
            frame_bytes <= 3'd1;
            frame_idx   <= '0;
            staging     <= '0;
        end else begin
            O_READ <= 1'b0;
            if (got_byte) pending <= 1'b0;
            if (running) acc <= tick ? (acc_sum[31:0] - SYSCLOCK) : acc_sum[31:0];
            if (I_PAUSE) begin
                O_PCM_L <= '0;
                O_PCM_R <= '0;
            end
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (I_START) begin
                        state    <= S_HDR;
                        addr     <= I_BASE_ADDR;
                        hdr_idx  <= '0;
                        underrun <= 1'b0;
                        acc      <= '0;
                        rate     <= '0;
                        O_PCM_L  <= '0;
                        O_PCM_R  <= '0;
                    end
                end
                S_HDR: begin
                    if (got_byte) begin
                        hdr_idx <= hdr_idx + 6'd1;
                        case (hdr_idx)
                            6'd22: num_ch[7:0]  <= I_DATA;
                            6'd23: num_ch[15:8] <= I_DATA;
                            6'd24, 6'd25, 6'd26, 6'd27: hdr_rate <= {I_DATA, hdr_rate[31:8]};
                            6'd34: bps[7:0]     <= I_DATA;
                            6'd35: bps[15:8]    <= I_DATA;
                            6'd40, 6'd41, 6'd42: size_lo <= {I_DATA, size_lo[23:8]};
                            default: ;
                        endcase
                        if (magic_bad) begin
                            state <= S_ERR;
                        end else if (hdr_idx == 6'd43) begin
                            if (hdr_bad) begin
                                state <= S_ERR;
                            end else begin
                                // Rate is committed only once the header is known good.
                                rate        <= hdr_rate;
                                data_start  <= addr;
                                end_addr    <= addr + ADDR_W'({I_DATA, size_lo});
                                stereo      <= (num_ch == 16'd2);
                                wide        <= (bps == 16'd16);
                                frame_bytes <= {(num_ch == 16'd2) && (bps == 16'd16),
                                                (num_ch == 16'd2) != (bps == 16'd16),
                                                (num_ch != 16'd2) && (bps != 16'd16)};
                                frame_idx   <= '0;
                                state       <= S_FETCH;
                            end
                        end
                    end else if (!pending && !I_PAUSE) begin
                        O_READ  <= 1'b1;
                        O_ADDR  <= addr;
                        addr    <= addr + 1'b1;
                        pending <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (tick && !I_PAUSE) underrun <= 1'b1;
                    if (got_byte) begin
                        staging[{frame_idx[1:0], 3'b000} +: 8] <= I_DATA;
                        frame_idx <= frame_idx + 3'd1;
                        if ((frame_idx + 3'd1) == frame_bytes) state <= S_WAIT;
                    end else if (!pending && !I_PAUSE) begin
                        if ((frame_idx == 3'd0) && at_end) begin
                            if (I_LOOP) begin
                                addr <= data_start;
                            end else begin
                                state   <= S_DONE;
                                O_PCM_L <= '0;
                                O_PCM_R <= '0;
                            end
                        end else begin
                            O_READ  <= 1'b1;
                            O_ADDR  <= addr;
                            addr    <= addr + 1'b1;
                            pending <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (tick && !I_PAUSE) begin
                        O_PCM_L   <= next_l;
                        O_PCM_R   <= next_r;
                        frame_idx <= '0;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_player.sv
// Scoreboard bench for wave_player: stimulus pushes expected PCM values, a monitor
// pops one per observed output change; a behavioural ROM answers reads with configurable latency.
module tb_wave_player;
    localparam int B = 'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        loop = 1'b0;
    logic        pause = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [27:0] base = 28'(B);
    logic [27:0] addr;
    logic        rd;
    logic [15:0] pcm_l;
    logic [15:0] pcm_r;
    logic        busy;
    logic        done;
    logic        err;
    logic        underrun;

    logic [7:0]  mem [0:4095];
    logic [7:0]  dat [$];
    logic [31:0] exp_q [$];
    int          chg_cyc [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          rd_count = 0;
    int          hdr_lat = 2;
    int          data_lat = 2;
    logic        mon_on = 1'b0;

    wave_player dut (
        .I_CLK(clk), .I_RST(rst), .I_START(start), .I_BASE_ADDR(base),
        .I_LOOP(loop), .I_PAUSE(pause), .O_ADDR(addr), .O_READ(rd),
        .I_DATA(data), .I_READY(ready), .O_PCM_L(pcm_l), .O_PCM_R(pcm_r),
        .O_BUSY(busy), .O_DONE(done), .O_ERR(err), .O_UNDERRUN(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: one request at a time, I_READY pulses `lat` cycles after O_READ is seen.
    initial begin
        logic [27:0] a;
        int lat;
        forever begin
            @(negedge clk);
            if (rd) begin
                a = addr;
                rd_count++;
                lat = (int'(a) >= B + 44) ? data_lat : hdr_lat;
                repeat (lat - 1) @(negedge clk);
                ready = 1'b1;
                data  = mem[a[11:0]];
                @(negedge clk);
                ready = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] prev, cur, e;
        prev = '0;
        wait (mon_on);
        forever begin
            @(negedge clk);
            cur = {pcm_l, pcm_r};
            if (cur !== prev) begin
                chg_cyc.push_back(cyc);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pcm_unexpected got %h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        miscompares++;
                        $display("FAIL pcm_seq got %h expected %h", cur, e);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_err(input int limit);
        int n = 0;
        while (!err && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_start(input logic [27:0] b);
        @(negedge clk);
        base  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        loop  = 1'b0;
        pause = 1'b0;
    endtask

    task automatic put(input int idx, input logic [7:0] v);
        mem[B + idx] = v;
    endtask

    task automatic put32(input int idx, input int v);
        for (int k = 0; k < 4; k++) mem[B + idx + k] = v[8*k +: 8];
    endtask

    task automatic put16(input int idx, input int v);
        for (int k = 0; k < 2; k++) mem[B + idx + k] = v[8*k +: 8];
    endtask

    task automatic build_wav(input int nch, input int rate, input int bps, input logic [7:0] b0);
        int n;
        n = dat.size();
        for (int i = 0; i < 128; i++) mem[B + i] = 8'hEE;
        put(0, b0);     put(1, 8'h49);  put(2, 8'h46);  put(3, 8'h46);
        put32(4, 36 + n);
        put(8, 8'h57);  put(9, 8'h41);  put(10, 8'h56); put(11, 8'h45);
        put(12, 8'h66); put(13, 8'h6D); put(14, 8'h74); put(15, 8'h20);
        put32(16, 16);
        put16(20, 1);
        put16(22, nch);
        put32(24, rate);
        put32(28, rate * nch * bps / 8);
        put16(32, nch * bps / 8);
        put16(34, bps);
        put(36, 8'h64); put(37, 8'h61); put(38, 8'h74); put(39, 8'h61);
        put32(40, n);
        for (int i = 0; i < n; i++) put(44 + i, dat[i]);
    endtask

    initial begin
        int rc;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;

        check("reset_pcm", {pcm_l, pcm_r}, 32'h0);
        check("reset_flags", {27'd0, rd, busy, done, err, underrun}, 32'h0);

        // Mono 8-bit at 8 kHz: three samples 5000 cycles apart, then DONE.
        dat = '{8'h00, 8'h80, 8'hFF};
        build_wav(1, 8000, 8, 8'h52);
        exp_q.push_back(32'h80008000);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h7F007F00);
        exp_q.push_back(32'h00000000);
        chg_cyc.delete();
        pulse_start(28'(B));
        drain("mono8_seq", 17000);
        if (chg_cyc.size() >= 3) begin
            check("mono8_interval1", chg_cyc[1] - chg_cyc[0], 32'd5000);
            check("mono8_interval2", chg_cyc[2] - chg_cyc[1], 32'd5000);
        end else begin
            check("mono8_changes", chg_cyc.size(), 32'd4);
        end
        check("mono8_done", {29'd0, busy, done, err}, 32'b010);

        // Stereo 16-bit; a START while busy must be ignored.
        do_reset();
        dat = '{8'h34, 8'h12, 8'hCD, 8'hAB};
        build_wav(2, 400000, 16, 8'h52);
        exp_q.push_back(32'h1234ABCD);
        exp_q.push_back(32'h00000000);
        pulse_start(28'(B));
        repeat (50) @(negedge clk);
        check("stereo16_busy", {31'd0, busy}, 32'd1);
        pulse_start(28'h800);
        drain("stereo16_seq", 1000);
        check("stereo16_done", {29'd0, busy, done, err}, 32'b010);

        // Loop over two mono 16-bit frames with read latency 3.
        do_reset();
        hdr_lat  = 3;
        data_lat = 3;
        dat = '{8'h00, 8'h11, 8'h00, 8'h22};
        build_wav(1, 400000, 16, 8'h52);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h11001100);
            exp_q.push_back(32'h22002200);
        end
        loop = 1'b1;
        pulse_start(28'(B));
        drain("loop_seq", 1500);
        check("loop_no_done", {30'd0, done, underrun}, 32'b00);
        exp_q.push_back(32'h0);
        do_reset();
        drain("loop_reset", 10);
        hdr_lat  = 2;
        data_lat = 2;

        // Underrun: data reads take 6000 cycles at 8 kHz.
        do_reset();
        data_lat = 6000;
        dat = '{8'h90, 8'hA0};
        build_wav(1, 8000, 8, 8'h52);
        exp_q.push_back(32'h10001000);
        pulse_start(28'(B));
        drain("underrun_first", 11000);
        check("underrun_flag", {31'd0, underrun}, 32'd1);
        exp_q.push_back(32'h20002000);
        exp_q.push_back(32'h00000000);
        repeat (5500) @(negedge clk);
        check("underrun_hold", {pcm_l, pcm_r}, 32'h10001000);
        drain("underrun_rest", 6000);
        check("underrun_done", {30'd0, done, underrun}, 32'b11);
        data_lat = 2;

        // Pause for 20000 cycles, then resume with the next frame.
        do_reset();
        dat = '{8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30};
        build_wav(1, 400000, 16, 8'h52);
        exp_q.push_back(32'h10001000);
        pulse_start(28'(B));
        drain("pause_first", 1000);
        exp_q.push_back(32'h0);
        pause = 1'b1;
        drain("pause_zero", 10);
        rc = rd_count;
        repeat (10000) @(negedge clk);
        check("pause_mid_pcm", {pcm_l, pcm_r}, 32'h0);
        repeat (10000) @(negedge clk);
        check("pause_no_reads", rd_count, rc);
        exp_q.push_back(32'h20002000);
        exp_q.push_back(32'h30003000);
        exp_q.push_back(32'h00000000);
        pause = 1'b0;
        drain("pause_resume", 1000);
        check("pause_done", {31'd0, done}, 32'd1);

        // Reset between O_READ and I_READY.
        do_reset();
        data_lat = 10;
        exp_q.push_back(32'h10001000);
        pulse_start(28'(B));
        drain("rstmid_first", 1000);
        rc = 0;
        while (!rd && rc < 200) begin
            @(negedge clk);
            rc++;
        end
        check("rstmid_read_seen", {31'd0, rd}, 32'd1);
        rst = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_pcm", {pcm_l, pcm_r}, 32'h0);
        check("rstmid_flags", {27'd0, rd, busy, done, err, underrun}, 32'h0);
        rc = rd_count;
        repeat (30) @(negedge clk);
        check("rstmid_idle", {27'd0, rd, busy, done, err, underrun}, 32'h0);
        check("rstmid_no_reads", rd_count, rc);
        drain("rstmid_zero", 5);
        data_lat = 2;

        // Bad magic byte 0.
        do_reset();
        dat = '{8'h10};
        build_wav(1, 400000, 8, 8'h58);
        rd_count = 0;
`ifdef WAVE_PLAYER_HDR_CHECK_EN
        pulse_start(28'(B));
        wait_err(30);
        repeat (10) @(negedge clk);
        check("magic_err", {30'd0, busy, err}, 32'b01);
        check("magic_reads", rd_count, 32'd1);
`else
        exp_q.push_back(32'h90009000);
        exp_q.push_back(32'h00000000);
        pulse_start(28'(B));
        drain("magic_ignored", 1000);
        check("magic_ignored_done", {30'd0, done, err}, 32'b10);
`endif

        // bits_per_sample = 24 rejected after the full header.
        do_reset();
        dat = '{8'h01, 8'h02, 8'h03};
        build_wav(1, 400000, 24, 8'h52);
        rd_count = 0;
        pulse_start(28'(B));
        wait_err(500);
        repeat (20) @(negedge clk);
        check("bps24_err", {30'd0, busy, err}, 32'b01);
        check("bps24_reads", rd_count, 32'd44);
        check("bps24_pcm", {pcm_l, pcm_r}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wave_player.md
WAVE_PLAYER -- requirements
Module: wave_player

Interface
REQ-001 Parameter SYSCLOCK, default 40000000: I_CLK frequency in Hz, used as the sample-rate accumulator modulus.
REQ-002 Parameter ADDR_W, default 28: byte-address width of the wave ROM.
REQ-003 I_CLK  in  1  clock; all logic on the rising edge.
REQ-004 I_RST  in  1  synchronous, active-high reset.
REQ-005 I_START  in  1  one-cycle pulse that begins playback from I_BASE_ADDR; ignored unless the state is IDLE, DONE or ERR.
REQ-006 I_BASE_ADDR  in  ADDR_W  byte address of the "RIFF" byte, sampled on I_START.
REQ-007 I_LOOP  in  1  when 1 at end of data, playback restarts at the first data byte.
REQ-008 I_PAUSE  in  1  freezes playback.
REQ-009 O_ADDR  out  ADDR_W  ROM byte address, valid while O_READ=1.
REQ-010 O_READ  out  1  one-cycle read request.
REQ-011 I_DATA  in  8  ROM byte, valid when I_READY=1.
REQ-012 I_READY  in  1  one-cycle pulse answering the oldest outstanding read.
REQ-013 O_PCM_L and O_PCM_R  out  16 each  signed PCM output, left and right.
REQ-014 O_BUSY, O_DONE, O_ERR, O_UNDERRUN  out  1 each  status flags.

Function
REQ-015 States: IDLE, HDR, FETCH, WAIT, DONE, ERR.
REQ-016 Handshake: at most one outstanding read; O_READ is asserted only with no read outstanding; latency from O_READ to I_READY is unbounded.
REQ-017 HDR: reads bytes base+0 to base+43 sequentially and captures the following little-endian fields:
- num_channels: bytes 22-23
- sample_rate: bytes 24-27
- bits_per_sample: bytes 34-35
- data_size: bytes 40-43
REQ-018 After byte 43: if num_channels is not 1 or 2, or bits_per_sample is not 8 or 16, the state goes to ERR; otherwise data_start = base+44, end_addr = data_start + data_size[ADDR_W-1:0], and the state goes to FETCH.
REQ-019 Frame size: 1 to 4 bytes, equal to num_channels*bits_per_sample/8. FETCH reads one frame sequentially into a staging register, then goes to WAIT.
REQ-020 8-bit samples are unsigned; conversion is {byte^8'h80, 8'h00}. 16-bit samples are little-endian signed.
REQ-021 Mono frames drive the same value on L and R.
REQ-022 Tick generation: a 32-bit accumulator adds sample_rate every cycle outside IDLE, DONE and ERR. When the sum is >= SYSCLOCK, the accumulator subtracts SYSCLOCK and a one-cycle tick is produced.
REQ-023 On a tick in WAIT with I_PAUSE=0: staging is copied to O_PCM_L and O_PCM_R, and the next frame is fetched.
REQ-024 A tick while FETCH is incomplete sets O_UNDERRUN (sticky until I_START or I_RST); outputs hold and the fetch continues.
REQ-025 End of data: when a frame fetch would start at an address >= end_addr:
- with I_LOOP=1, the address reloads to data_start and fetching continues;
- otherwise the state goes to DONE.
REQ-026 If data_size is not a multiple of the frame size, the trailing partial frame is discarded.
REQ-027 I_PAUSE=1: ticks are ignored, outputs read 0, and the address and staging are preserved; playback resumes from the staged frame.
REQ-028 An in-flight read completes during pause.
REQ-029 In DONE and ERR, outputs read 0.
REQ-030 Status flags:
- O_BUSY=1 in HDR, FETCH and WAIT;
- O_DONE=1 in DONE;
- O_ERR=1 in ERR.
REQ-031 I_START and a tick in the same cycle: I_START wins.
REQ-032 I_START in any state other than IDLE, DONE or ERR is ignored.

Reset
REQ-033 I_RST has priority over all inputs and takes effect in any state, including mid-read. Its effects:
- state goes to IDLE;
- O_READ=0, O_PCM_L=O_PCM_R=0, all flags 0;
- accumulator cleared;
- outstanding-read tracking cleared, and any I_READY arriving after reset is ignored.

Configuration
REQ-034 Macro WAVE_PLAYER_HDR_CHECK_EN controls RIFF/WAVE magic checking.
REQ-035 With WAVE_PLAYER_HDR_CHECK_EN defined: bytes 0-3 must equal "RIFF" and bytes 8-11 must equal "WAVE". On the first mismatching byte, reading stops and the state goes to ERR.
REQ-036 Without WAVE_PLAYER_HDR_CHECK_EN: magic bytes are read but ignored.

Verification
REQ-037 Mono/8-bit: SYSCLOCK=40000000, sample_rate=8000, bytes 00,80,FF -> O_PCM_L=O_PCM_R = 8000h, 0000h, 7F00h, one value per 5000 cycles, then O_DONE=1.
REQ-038 Stereo/16-bit: data 34 12 CD AB -> O_PCM_L=1234h, O_PCM_R=ABCDh on the first tick after the fetch completes.
REQ-039 Loop: I_LOOP=1 with 2 mono 16-bit frames -> output sequence F0,F1,F0,F1,..., O_DONE stays 0, and no O_UNDERRUN when I_READY latency is 3 cycles.
REQ-040 Error: header byte 0 = "X" -> with WAVE_PLAYER_HDR_CHECK_EN, O_ERR=1 after the 1st byte; without it, playback proceeds. Separately, bits_per_sample=24 -> O_ERR=1 after byte 43.
REQ-041 Underrun: I_READY latency of 6000 cycles at 8 kHz -> O_UNDERRUN=1 and the previous output holds.
REQ-042 Pause and reset mid-read: I_PAUSE=1 for 20000 cycles -> outputs 0, then on release the stream resumes with the next frame value. I_RST asserted between O_READ and I_READY -> all outputs 0 next cycle, the late I_READY is ignored, and state is IDLE.
